// File: rtl/carbon_arch_pkg.sv
// Shared fabric constants, opcode/response encodings and responder state type.
package carbon_arch_pkg;

    localparam int unsigned CARBON_FABRIC_ATTR_WIDTH_BITS = 8;

    localparam logic [7:0] CARBON_FABRIC_OP_READ  = 8'h00;
    localparam logic [7:0] CARBON_FABRIC_OP_WRITE = 8'h01;

    localparam logic [7:0] CARBON_FABRIC_RESP_OK          = 8'h00;
    localparam logic [7:0] CARBON_FABRIC_RESP_DECODE_ERR  = 8'h01;
    localparam logic [7:0] CARBON_FABRIC_RESP_ALIGN_ERR   = 8'h02;
    localparam logic [7:0] CARBON_FABRIC_RESP_UNSUPPORTED = 8'h03;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_RESP = 2'd2
    } fmr_state_e;

endpackage

// File: rtl/fabric_sram_1rw.sv
// Single-port SRAM with per-byte write enables and a registered read port.
module fabric_sram_1rw #(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                clk,
    input  logic                en_i,
    input  logic                we_i,
    input  logic [AW-1:0]       addr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W/8-1:0] wstrb_i,
    output logic [DATA_W-1:0]   rdata_o
);

    localparam int unsigned LANES = DATA_W / 8;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Byte-lane write or registered read; contents are never reset.
    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                for (int unsigned b = 0; b < LANES; b++) begin
                    if (wstrb_i[b]) begin
                        mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/fabric_mem_responder.sv
// Single-outstanding fabric memory responder: decodes, checks and services
// read/write requests against a local SRAM and returns one response each.
module fabric_mem_responder
    import carbon_arch_pkg::*;
#(
    parameter int unsigned     ADDR_W    = 32,
    parameter int unsigned     DATA_W    = 32,
    parameter int unsigned     ID_W      = 4,
    parameter int unsigned     OP_W      = 8,
    parameter int unsigned     SIZE_W    = 3,
    parameter int unsigned     ATTR_W    = CARBON_FABRIC_ATTR_WIDTH_BITS,
    parameter int unsigned     CODE_W    = 8,
    parameter int unsigned     DEPTH     = 256,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [OP_W-1:0]     req_op,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_wstrb,
    input  logic [SIZE_W-1:0]   req_size,
    input  logic [ATTR_W-1:0]   req_attr,
    input  logic [ID_W-1:0]     req_id,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic [CODE_W-1:0]   rsp_code,
    output logic [ID_W-1:0]     rsp_id,
    output logic [15:0]         err_cnt
);

    localparam int unsigned LANE_BITS = $clog2(DATA_W / 8);
    localparam int unsigned MEM_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fmr_state_e        state_q, state_d;
    logic              req_ready_q, rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [CODE_W-1:0] rsp_code_q, rsp_code_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic [15:0]       err_cnt_q, err_cnt_d;

    logic [ADDR_W-1:0] offset_c, index_c, align_mask_c;
    logic [CODE_W-1:0] code_c;
    logic              sram_en_c, sram_we_c;
    logic [DATA_W-1:0] sram_rdata;
    logic              unused_attr;

    assign unused_attr = ^req_attr;

    // Response code for the presented request: first failing rule wins.
    always_comb begin
        offset_c     = req_addr - BASE_ADDR;
        index_c      = offset_c >> LANE_BITS;
        align_mask_c = (ADDR_W'(1) << req_size) - ADDR_W'(1);
        code_c       = CODE_W'(CARBON_FABRIC_RESP_OK);
        if ((req_op != OP_W'(CARBON_FABRIC_OP_READ)) && (req_op != OP_W'(CARBON_FABRIC_OP_WRITE))) begin
            code_c = CODE_W'(CARBON_FABRIC_RESP_UNSUPPORTED);
        end else if (req_size > SIZE_W'(LANE_BITS)) begin
            code_c = CODE_W'(CARBON_FABRIC_RESP_UNSUPPORTED);
        end else if ((req_addr & align_mask_c) != '0) begin
            code_c = CODE_W'(CARBON_FABRIC_RESP_ALIGN_ERR);
        end else if ((req_addr < BASE_ADDR) || (index_c >= ADDR_W'(DEPTH))) begin
            code_c = CODE_W'(CARBON_FABRIC_RESP_DECODE_ERR);
        end
    end

    // Next-state, response payload, SRAM strobes and error counter.
    always_comb begin
        state_d     = state_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_code_d  = rsp_code_q;
        rsp_id_d    = rsp_id_q;
        err_cnt_d   = err_cnt_q;
        sram_en_c   = 1'b0;
        sram_we_c   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    rsp_id_d    = req_id;
                    rsp_code_d  = code_c;
                    rsp_rdata_d = '0;
                    state_d     = ST_RESP;
                    if (code_c == CODE_W'(CARBON_FABRIC_RESP_OK)) begin
                        sram_en_c = 1'b1;
                        sram_we_c = (req_op == OP_W'(CARBON_FABRIC_OP_WRITE));
                        if (req_op == OP_W'(CARBON_FABRIC_OP_READ)) begin
                            state_d = ST_READ;
                        end
                    end
                end
            end
            ST_READ: begin
                rsp_rdata_d = sram_rdata;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                    if ((rsp_code_q != CODE_W'(CARBON_FABRIC_RESP_OK)) && (err_cnt_q != 16'hFFFF)) begin
                        err_cnt_d = err_cnt_q + 16'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs; reset discards any in-flight transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_code_q  <= '0;
            rsp_id_q    <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= (state_d == ST_IDLE);
            rsp_valid_q <= (state_d == ST_RESP);
            rsp_rdata_q <= rsp_rdata_d;
            rsp_code_q  <= rsp_code_d;
            rsp_id_q    <= rsp_id_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    fabric_sram_1rw #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .AW     (MEM_AW)
    ) u_sram (
        .clk     (clk),
        .en_i    (sram_en_c),
        .we_i    (sram_we_c),
        .addr_i  (index_c[MEM_AW-1:0]),
        .wdata_i (req_wdata),
        .wstrb_i (req_wstrb),
        .rdata_o (sram_rdata)
    );

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_code  = rsp_code_q;
    assign rsp_id    = rsp_id_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_fabric_mem_responder.sv
// Self-checking bench for fabric_mem_responder with an array-based memory model.
module tb_fabric_mem_responder;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ID_W   = 4;
    localparam int unsigned OP_W   = 8;
    localparam int unsigned SIZE_W = 3;
    localparam int unsigned ATTR_W = carbon_arch_pkg::CARBON_FABRIC_ATTR_WIDTH_BITS;
    localparam int unsigned CODE_W = 8;
    localparam int unsigned DEPTH  = 256;
    localparam logic [31:0] BASE   = 32'h1000;

    logic              clk, rst;
    logic              req_valid, req_ready;
    logic [OP_W-1:0]   req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [3:0]        req_wstrb;
    logic [SIZE_W-1:0] req_size;
    logic [ATTR_W-1:0] req_attr;
    logic [ID_W-1:0]   req_id;
    logic              rsp_valid, rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic [CODE_W-1:0] rsp_code;
    logic [ID_W-1:0]   rsp_id;
    logic [15:0]       err_cnt;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] err_model = '0;
    logic [31:0] mem_m [DEPTH];

    fabric_mem_responder #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .OP_W(OP_W), .SIZE_W(SIZE_W),
        .ATTR_W(ATTR_W), .CODE_W(CODE_W), .DEPTH(DEPTH), .BASE_ADDR(BASE)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_size(req_size), .req_attr(req_attr),
        .req_id(req_id), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_code(rsp_code), .rsp_id(rsp_id), .err_cnt(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference response code straight from the ordered decode rules.
    function automatic logic [7:0] model_code(logic [7:0] op, logic [31:0] addr, logic [2:0] size);
        if (op > 8'd1) return 8'h03;
        if (size > 3'd2) return 8'h03;
        if ((addr % (32'd1 << size)) != 0) return 8'h02;
        if (addr < BASE || ((addr - BASE) / 4) >= DEPTH) return 8'h01;
        return 8'h00;
    endfunction

    // Reference effect of one transaction on memory, read data and error count.
    function automatic void model_apply(input logic [7:0] op, input logic [31:0] addr,
                                        input logic [31:0] wdata, input logic [3:0] wstrb,
                                        input logic [2:0] size,
                                        output logic [31:0] rd, output logic [7:0] code);
        int idx;
        code = model_code(op, addr, size);
        rd   = '0;
        if (code == 8'h00) begin
            idx = int'((addr - BASE) / 4);
            if (op == 8'h01) begin
                for (int b = 0; b < 4; b++) if (wstrb[b]) mem_m[idx][8*b +: 8] = wdata[8*b +: 8];
            end else begin
                rd = mem_m[idx];
            end
        end else if (err_model != 16'hFFFF) begin
            err_model = err_model + 16'd1;
        end
    endfunction

    // Drive one request, measure accept-to-valid latency, capture and consume the response.
    task automatic run_txn(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, input logic [2:0] size, input logic [3:0] id,
                           input int stall, output logic [31:0] rd, output logic [7:0] code,
                           output logic [3:0] rid, output int lat);
        int n = 0;
        while (req_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        req_op = op; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb;
        req_size = size; req_id = id; req_attr = ATTR_W'($urandom);
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 10) begin @(posedge clk); #1; lat++; end
        if (rsp_valid !== 1'b1) begin
            checks++; errors++;
            $display("FAIL rsp_timeout: rsp_valid=%b after %0d cycles, required 1", rsp_valid, lat);
            rd = 'x; code = 'x; rid = 'x;
            return;
        end
        rd = rsp_rdata; code = rsp_code; rid = rsp_id;
        repeat (stall) begin @(posedge clk); #1; end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        req_op = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0; req_size = '0; req_attr = '0; req_id = '0;
        #2;
        checks++; if ({req_ready, rsp_valid} !== 2'b10) begin errors++; $display("FAIL reset_hs: got ready/valid %b required 10", {req_ready, rsp_valid}); end
        checks++; if ({rsp_rdata, rsp_code, rsp_id, err_cnt} !== '0) begin errors++; $display("FAIL reset_fields: got %h required 0", {rsp_rdata, rsp_code, rsp_id, err_cnt}); end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        logic [31:0] rd, erd; logic [7:0] code, ecode; logic [3:0] rid; int lat;
        model_apply(8'h01, 32'h1004, 32'hDEADBEEF, 4'hF, 3'd2, erd, ecode);
        run_txn(8'h01, 32'h1004, 32'hDEADBEEF, 4'hF, 3'd2, 4'd3, 0, rd, code, rid, lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL wr_latency: got %0d required 1", lat); end
        checks++; if ({code, rid, rd} !== {8'h00, 4'd3, 32'h0}) begin errors++; $display("FAIL wr_rsp: got code %h id %h rdata %h required 00 3 00000000", code, rid, rd); end
        model_apply(8'h00, 32'h1004, 32'h0, 4'h0, 3'd2, erd, ecode);
        run_txn(8'h00, 32'h1004, 32'h0, 4'h0, 3'd2, 4'd5, 0, rd, code, rid, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL rd_latency: got %0d required 2", lat); end
        checks++; if ({code, rid, rd} !== {8'h00, 4'd5, 32'hDEADBEEF}) begin errors++; $display("FAIL rd_rsp: got code %h id %h rdata %h required 00 5 deadbeef", code, rid, rd); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b required 1", req_ready); end
    endtask

    task automatic test_strobe();
        logic [31:0] rd, erd; logic [7:0] code, ecode; logic [3:0] rid; int lat;
        model_apply(8'h01, 32'h1004, 32'h0000AA00, 4'h2, 3'd2, erd, ecode);
        run_txn(8'h01, 32'h1004, 32'h0000AA00, 4'h2, 3'd2, 4'd1, 0, rd, code, rid, lat);
        model_apply(8'h00, 32'h1004, 32'h0, 4'h0, 3'd2, erd, ecode);
        run_txn(8'h00, 32'h1004, 32'h0, 4'h0, 3'd2, 4'd2, 0, rd, code, rid, lat);
        checks++; if (rd !== 32'hDEADAAEF) begin errors++; $display("FAIL strobe_rd: got %h required deadaaef", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd, erd; logic [7:0] code, ecode; logic [3:0] rid; int lat;
        model_apply(8'h00, 32'h1002, 32'h0, 4'h0, 3'd2, erd, ecode);
        run_txn(8'h00, 32'h1002, 32'h0, 4'h0, 3'd2, 4'd6, 0, rd, code, rid, lat);
        checks++; if ({code, rd, lat} !== {8'h02, 32'h0, 32'd1}) begin errors++; $display("FAIL align: got code %h rdata %h lat %0d required 02 0 1", code, rd, lat); end
        model_apply(8'h00, 32'h0FFC, 32'h0, 4'h0, 3'd2, erd, ecode);
        run_txn(8'h00, 32'h0FFC, 32'h0, 4'h0, 3'd2, 4'd7, 0, rd, code, rid, lat);
        checks++; if ({code, rd} !== {8'h01, 32'h0}) begin errors++; $display("FAIL decode: got code %h rdata %h required 01 0", code, rd); end
        model_apply(8'h07, 32'h1004, 32'h0, 4'h0, 3'd2, erd, ecode);
        run_txn(8'h07, 32'h1004, 32'h0, 4'h0, 3'd2, 4'd8, 0, rd, code, rid, lat);
        checks++; if ({code, rid} !== {8'h03, 4'd8}) begin errors++; $display("FAIL unsupported: got code %h id %h required 03 8", code, rid); end
        checks++; if (err_cnt !== 16'd3) begin errors++; $display("FAIL err_cnt3: got %0d required 3", err_cnt); end
    endtask

    task automatic test_stall();
        logic [31:0] rd; logic [7:0] code; logic [3:0] rid;
        req_op = 8'h00; req_addr = 32'h1004; req_size = 3'd2; req_id = 4'd9; req_wstrb = '0;
        req_valid = 1'b1;
        @(posedge clk); #1; req_valid = 1'b0;
        @(posedge clk); #1;
        rd = rsp_rdata; code = rsp_code; rid = rsp_id;
        checks++; if ({rsp_valid, rd, code, rid} !== {1'b1, 32'hDEADAAEF, 8'h00, 4'd9}) begin errors++; $display("FAIL stall_first: got v %b rdata %h code %h id %h required 1 deadaaef 00 9", rsp_valid, rd, code, rid); end
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                req_op = 8'h01; req_addr = 32'h1004; req_wdata = 32'h12345678; req_wstrb = 4'hF; req_id = 4'hA;
                req_valid = 1'b1;
            end
            @(posedge clk); #1;
            checks++; if ({rsp_valid, req_ready, rsp_rdata, rsp_code, rsp_id} !== {1'b1, 1'b0, rd, code, rid}) begin
                errors++; $display("FAIL stall_hold%0d: got v %b rdy %b rdata %h code %h id %h", i, rsp_valid, req_ready, rsp_rdata, rsp_code, rsp_id);
            end
        end
        req_valid = 1'b0; rsp_ready = 1'b1;
        @(posedge clk); #1; rsp_ready = 1'b0;
        @(posedge clk); #1;
        checks++; if ({rsp_valid, req_ready} !== 2'b01) begin errors++; $display("FAIL stall_ignored: got v/rdy %b required 01", {rsp_valid, req_ready}); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic [7:0] code; logic [3:0] rid; int lat;
        req_op = 8'h00; req_addr = 32'h1004; req_size = 3'd2; req_id = 4'd4;
        req_valid = 1'b1;
        @(posedge clk); #1; req_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++; if ({rsp_valid, req_ready, err_cnt} !== {1'b0, 1'b1, 16'd0}) begin errors++; $display("FAIL rst_mid: got v %b rdy %b err %0d required 0 1 0", rsp_valid, req_ready, err_cnt); end
        err_model = '0;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        checks++; if ({rsp_valid, req_ready} !== 2'b01) begin errors++; $display("FAIL rst_no_rsp: got v/rdy %b required 01", {rsp_valid, req_ready}); end
        run_txn(8'h00, 32'h1004, 32'h0, 4'h0, 3'd2, 4'd2, 0, rd, code, rid, lat);
        checks++; if (rd !== 32'hDEADAAEF) begin errors++; $display("FAIL rst_persist: got %h required deadaaef", rd); end
    endtask

    task automatic test_random();
        logic [31:0] rd, erd, addr, wdata; logic [7:0] code, ecode, op; logic [3:0] rid, id, wstrb;
        logic [2:0] size; int lat, sel;
        int words [8] = '{1, 3, 40, 77, 128, 200, 254, 255};
        for (int k = 0; k < 8; k++) begin
            addr = BASE + 32'(words[k] * 4); wdata = $urandom;
            model_apply(8'h01, addr, wdata, 4'hF, 3'd2, erd, ecode);
            run_txn(8'h01, addr, wdata, 4'hF, 3'd2, 4'd0, 0, rd, code, rid, lat);
        end
        for (int n = 0; n < 60; n++) begin
            sel = $urandom_range(0, 9);
            if (sel < 8) addr = BASE + 32'(words[sel] * 4) + 32'($urandom_range(0, 3));
            else if (sel == 8) addr = BASE - 32'(4 * $urandom_range(1, 4));
            else addr = BASE + 32'(DEPTH * 4) + 32'(4 * $urandom_range(0, 3));
            sel = $urandom_range(0, 9);
            op = (sel < 4) ? 8'h00 : (sel < 8) ? 8'h01 : 8'($urandom_range(2, 255));
            size = 3'($urandom_range(0, 3)); wstrb = 4'($urandom); wdata = $urandom; id = 4'($urandom);
            model_apply(op, addr, wdata, wstrb, size, erd, ecode);
            run_txn(op, addr, wdata, wstrb, size, id, $urandom_range(0, 2), rd, code, rid, lat);
            checks++; if ({code, rid, rd} !== {ecode, id, erd}) begin
                errors++; $display("FAIL rand%0d: op %h addr %h size %0d got code %h id %h rdata %h required %h %h %h", n, op, addr, size, code, rid, rd, ecode, id, erd);
            end
            checks++; if (lat !== ((ecode == 8'h00 && op == 8'h00) ? 2 : 1)) begin errors++; $display("FAIL rand_lat%0d: got %0d", n, lat); end
            checks++; if (err_cnt !== err_model) begin errors++; $display("FAIL rand_err%0d: got %0d required %0d", n, err_cnt, err_model); end
        end
    endtask

    task automatic test_saturate();
        logic [31:0] rd; logic [7:0] code; logic [3:0] rid; int lat;
        force dut.err_cnt_q = 16'hFFFF;
        @(posedge clk); #1;
        release dut.err_cnt_q;
        @(posedge clk); #1;
        checks++; if (err_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_preset: got %h required ffff", err_cnt); end
        run_txn(8'h00, 32'h0FFC, 32'h0, 4'h0, 3'd2, 4'd1, 0, rd, code, rid, lat);
        checks++; if ({code, err_cnt} !== {8'h01, 16'hFFFF}) begin errors++; $display("FAIL sat_hold: got code %h err %h required 01 ffff", code, err_cnt); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_strobe();
        test_errors();
        test_stall();
        test_reset_mid();
        test_random();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
